// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter and its round-robin picker.
package mult_pkg;

  localparam int OP_W        = 4;
  localparam int PROD_W      = 8;
  localparam int TIMEOUT_DEF = 32;
  localparam int TIMER_W     = $clog2(TIMEOUT_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Index width for an n-entry vector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Timer width able to hold the value timeout-1.
  function automatic int timer_w(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request strictly after
// ptr (with wrap-around) wins. Reusable for any shared-resource scheduler.
module rr_pick
  import mult_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan ptr+1 .. ptr+N modulo N; the first hit latches into gnt/idx.
  always_comb begin
    logic [IW-1:0] j_s;
    logic          hit_s;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j_s      = IW'((int'(ptr) + k) % N);
      hit_s    = !any && req[j_s];
      gnt[j_s] = gnt[j_s] | hit_s;
      idx      = hit_s ? j_s : idx;
      any      = any | hit_s;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one shift-add multiplier among N_REQ
// requesters. One transaction at a time: grant, init pulse, wait for done
// (or timeout), then a one-cycle response pulse to the winner.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [OP_W*N_REQ-1:0]   op_a,
  input  logic [OP_W*N_REQ-1:0]   op_b,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [PROD_W-1:0]       resp_data,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    mul_init,
  output logic [OP_W-1:0]         mul_ma,
  output logic [OP_W-1:0]         mul_mb,
  input  logic                    mul_done,
  input  logic [PROD_W-1:0]       mul_producto
);

  localparam int             IW      = idx_w(N_REQ);
  localparam int             TW      = timer_w(TIMEOUT);
  localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0]  PTR_RST = IW'(N_REQ - 1);

  state_t            state_r;
  logic [IW-1:0]     ptr_r;
  logic [IW-1:0]     win_r;
  logic [TW-1:0]     timer_r;

  logic [N_REQ-1:0]  pick_gnt_s;
  logic [IW-1:0]     pick_idx_s;
  logic              pick_any_s;
  logic [OP_W-1:0]   sel_a_s;
  logic [OP_W-1:0]   sel_b_s;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req (req),
    .ptr (ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // Operand mux driven by the one-hot pick, so no variable part-selects.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_a_s = sel_a_s | (op_a[i*OP_W +: OP_W] & {OP_W{pick_gnt_s[i]}});
      sel_b_s = sel_b_s | (op_b[i*OP_W +: OP_W] & {OP_W{pick_gnt_s[i]}});
    end
  end

  // Scheduler FSM; every output is a register. Done is only looked at in
  // WAIT, so a late done from an aborted or timed-out job is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= PTR_RST;
      win_r      <= '0;
      timer_r    <= '0;
      gnt        <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      mul_init   <= 1'b0;
      mul_ma     <= '0;
      mul_mb     <= '0;
    end else begin
      gnt        <= '0;
      resp_valid <= '0;
      mul_init   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            gnt     <= pick_gnt_s;
            win_r   <= pick_idx_s;
            mul_ma  <= sel_a_s;
            mul_mb  <= sel_b_s;
            busy    <= 1'b1;
            state_r <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          mul_init <= 1'b1;
          timer_r  <= '0;
          state_r  <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            resp_data         <= mul_producto;
            resp_err          <= 1'b0;
            resp_valid[win_r] <= 1'b1;
            state_r           <= RESP;
          end else if (timer_r == T_LAST) begin
            resp_data         <= '0;
            resp_err          <= 1'b1;
            resp_valid[win_r] <= 1'b1;
            state_r           <= RESP;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        RESP: begin
          ptr_r   <= win_r;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural multiplier stub.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int TO = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [4*N-1:0] op_a, op_b;
  logic [N-1:0]   gnt, resp_valid;
  logic [7:0]     resp_data;
  logic           resp_err, busy, mul_init;
  logic [3:0]     mul_ma, mul_mb;
  logic           mul_done;
  logic [7:0]     mul_producto;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_init   = 0;

  typedef struct {int idx; logic [7:0] data; logic err;} exp_t;
  exp_t exp_q[$];
  int   gnt_q[$];

  // Multiplier stub: no reset, done one cycle wide after lat cycles.
  int         lat   = 4;
  bit         never = 1'b0;
  bit         stray = 1'b0;
  bit         sbusy = 1'b0;
  int         scnt  = 0;
  logic [3:0] sa = 4'd0, sb = 4'd0;
  logic       done_r = 1'b0;
  logic [7:0] prod_r = 8'd0;
  logic       init_prev = 1'b0;

  assign mul_done     = done_r | stray;
  assign mul_producto = stray ? 8'hAA : prod_r;

  mult_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy), .mul_init(mul_init),
    .mul_ma(mul_ma), .mul_mb(mul_mb), .mul_done(mul_done),
    .mul_producto(mul_producto)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    done_r <= 1'b0;
    if (mul_init) begin
      sbusy <= !never;
      scnt  <= lat;
      sa    <= mul_ma;
      sb    <= mul_mb;
    end else if (sbusy) begin
      if (scnt == 0) begin
        done_r <= 1'b1;
        prod_r <= {4'd0, sa} * {4'd0, sb};
        sbusy  <= 1'b0;
      end else begin
        scnt <= scnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic push_exp(input int i, input logic [7:0] d, input logic e);
    exp_t x;
    x.idx = i; x.data = d; x.err = e;
    exp_q.push_back(x);
    gnt_q.push_back(i);
  endtask

  // Monitor: pops the scoreboard on every grant and response pulse.
  always @(negedge clk) begin
    exp_t       e;
    logic [N-1:0] ev;
    int         gi;
    if (!rst) begin
      if (mul_init) begin
        chk("init_width", 32'(init_prev), 32'd0);
        if (!init_prev) n_init++;
      end
      init_prev <= mul_init;
      if (gnt != '0) begin
        if (gnt_q.size() == 0) begin
          chk("unexpected_gnt", 32'(gnt), 32'd0);
        end else begin
          gi = gnt_q.pop_front();
          ev = '0; ev[gi] = 1'b1;
          chk("gnt", 32'(gnt), 32'(ev));
        end
      end
      if (resp_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          e  = exp_q.pop_front();
          ev = '0; ev[e.idx] = 1'b1;
          chk("resp_valid", 32'(resp_valid), 32'(ev));
          chk("resp_data", 32'(resp_data), 32'(e.data));
          chk("resp_err", 32'(resp_err), 32'(e.err));
        end
      end
    end else begin
      init_prev <= 1'b0;
    end
  end

  // Hold req[i] until n responses to requester i have been seen.
  task automatic drive(input int i, input logic [3:0] a, input logic [3:0] b, input int n);
    int got = 0;
    int t   = 0;
    op_a[4*i +: 4] = a;
    op_b[4*i +: 4] = b;
    req[i] = 1'b1;
    while (got < n && t < 400) begin
      @(negedge clk);
      t++;
      if (resp_valid[i]) got++;
    end
    chk("drive_responses", 32'(got), 32'(n));
    req[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_data"}, 32'(resp_data), 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_mul_init"}, 32'(mul_init), 32'd0);
    chk({tag, "_mul_ma"}, 32'(mul_ma), 32'd0);
    chk({tag, "_mul_mb"}, 32'(mul_mb), 32'd0);
  endtask

  task automatic wait_init(output int c);
    int t = 0;
    while (!mul_init && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("saw_mul_init", 32'(mul_init), 32'd1);
    c = cyc;
  endtask

  initial begin
    int ni0, ti, tr, t;
    rst = 1'b1; req = '0; op_a = '0; op_b = '0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single requester 3*5
    ni0 = n_init;
    push_exp(0, 8'd15, 1'b0);
    drive(0, 4'd3, 4'd5, 1);
    chk("single_init_count", 32'(n_init - ni0), 32'd1);

    // Simultaneous requests after reset: 0 first, then 2
    do_reset();
    push_exp(0, 8'd14, 1'b0);
    push_exp(2, 8'd81, 1'b0);
    fork
      drive(0, 4'd2, 4'd7, 1);
      drive(2, 4'd9, 4'd9, 1);
    join

    // Fairness: all four held for two transactions each
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push_exp(0, 8'd2, 1'b0);
      push_exp(1, 8'd12, 1'b0);
      push_exp(2, 8'd30, 1'b0);
      push_exp(3, 8'd56, 1'b0);
    end
    fork
      drive(0, 4'd1, 4'd2, 2);
      drive(1, 4'd3, 4'd4, 2);
      drive(2, 4'd5, 4'd6, 2);
      drive(3, 4'd7, 4'd8, 2);
    join

    // Boundary operands
    push_exp(1, 8'd225, 1'b0);
    drive(1, 4'd15, 4'd15, 1);
    push_exp(2, 8'd0, 1'b0);
    drive(2, 4'd0, 4'd9, 1);
    push_exp(3, 8'd0, 1'b0);
    drive(3, 4'd9, 4'd0, 1);

    // Timeout: stub never answers
    never = 1'b1;
    push_exp(0, 8'd0, 1'b1);
    op_a[3:0] = 4'd5; op_b[3:0] = 4'd5; req[0] = 1'b1;
    wait_init(ti);
    t = 0;
    while (!resp_valid[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    tr = cyc;
    req[0] = 1'b0;
    chk("timeout_latency", 32'(tr - ti), 32'(TO));
    never = 1'b0;
    repeat (3) @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_done_busy", 32'(busy), 32'd0);
    push_exp(1, 8'd21, 1'b0);
    drive(1, 4'd7, 4'd3, 1);

    // Reset in the middle of WAIT
    lat = 12;
    gnt_q.push_back(2);
    op_a[11:8] = 4'd5; op_b[11:8] = 4'd5; req[2] = 1'b1;
    wait_init(ti);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("midwait_rst");
    req[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("late_done_busy", 32'(busy), 32'd0);
    lat = 3;
    push_exp(0, 8'd24, 1'b0);
    drive(0, 4'd6, 4'd4, 1);

    repeat (5) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

endmodule
